// File: rtl/riscv_pkg.sv
// Shared definitions for the core datapath.
//   XLEN    : native data width, used as the default payload width
//   DEST_D1 : in_sel encoding that steers a beat to destination d1
//   DEST_D2 : in_sel encoding that steers a beat to destination d2
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic DEST_D1 = 1'b0;
    localparam logic DEST_D2 = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a zero-when-empty head.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   flush     : synchronous clear; push and pop in the same cycle are ignored
//   push      : write wdata at the tail (ignored when full)
//   pop       : advance the head (ignored when empty)
//   wdata     : payload to write
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : current occupancy, 0..DEPTH
//   head      : oldest entry, or 0 when empty
module sync_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full  & ~flush;
    assign do_pop  = pop  & ~empty & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; the zero-when-empty head hides stale data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign count = cnt;
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/demux1_2_q.sv
// Queued 1:2 demultiplexer. Each producer beat is steered by in_sel into
// the d1 (sel=0) or d2 (sel=1) queue; each destination drains independently.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   flush               : synchronous clear of both queues
//   in_valid/sel/data   : producer beat and its destination
//   in_ready            : beat accepted when in_valid && in_ready
//   d1_valid/data/ready : d1 queue head handshake
//   d2_valid/data/ready : d2 queue head handshake
//   d1_count, d2_count  : per-queue occupancy
module demux1_2_q
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic                       in_sel,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       d1_valid,
    output logic [WIDTH-1:0]           d1_data,
    input  logic                       d1_ready,
    output logic                       d2_valid,
    output logic [WIDTH-1:0]           d2_data,
    input  logic                       d2_ready,
    output logic [$clog2(DEPTH):0]     d1_count,
    output logic [$clog2(DEPTH):0]     d2_count
);

    logic d1_full, d2_full;
    logic d1_empty, d2_empty;
    logic push_d1, push_d2;

    // Acceptance looks only at registered fullness, never at the consumer
    // readies, so a full queue refuses a push even while it is being popped.
    assign in_ready = ~flush & ~((in_sel == DEST_D2) ? d2_full : d1_full);

    assign push_d1 = in_valid & in_ready & (in_sel == DEST_D1);
    assign push_d2 = in_valid & in_ready & (in_sel == DEST_D2);

    assign d1_valid = ~d1_empty;
    assign d2_valid = ~d2_empty;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_q_d1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push_d1),
        .pop   (d1_valid & d1_ready),
        .wdata (in_data),
        .full  (d1_full),
        .empty (d1_empty),
        .count (d1_count),
        .head  (d1_data)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_q_d2 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push_d2),
        .pop   (d2_valid & d2_ready),
        .wdata (in_data),
        .full  (d2_full),
        .empty (d2_empty),
        .count (d2_count),
        .head  (d2_data)
    );

endmodule

// File: tb/tb_demux1_2_q.sv
// Self-checking bench for demux1_2_q: queue-based scoreboard per destination.
module tb_demux1_2_q;

    localparam int unsigned W = 32;
    localparam int unsigned D = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_sel;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         d1_valid, d2_valid;
    logic [W-1:0] d1_data, d2_data;
    logic         d1_ready, d2_ready;
    logic [1:0]   d1_count, d2_count;

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];

    always #5 clk = ~clk;

    demux1_2_q #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .in_ready (in_ready),
        .d1_valid (d1_valid),
        .d1_data  (d1_data),
        .d1_ready (d1_ready),
        .d2_valid (d2_valid),
        .d2_data  (d2_data),
        .d2_ready (d2_ready),
        .d1_count (d1_count),
        .d2_count (d2_count)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " d1_valid"}, W'(d1_valid), '0);
        chk({tag, " d2_valid"}, W'(d2_valid), '0);
        chk({tag, " d1_count"}, W'(d1_count), '0);
        chk({tag, " d2_count"}, W'(d2_count), '0);
        chk({tag, " d1_data"},  d1_data,      '0);
        chk({tag, " d2_data"},  d2_data,      '0);
    endtask

    // One cycle: drive, compare against the scoreboard mid-cycle, update it, clock.
    task automatic step(input logic v, input logic s, input logic [W-1:0] d,
                        input logic r1, input logic r2, input logic f);
        logic exp_ir;
        in_valid = v; in_sel = s; in_data = d;
        d1_ready = r1; d2_ready = r2; flush = f;
        #2;
        exp_ir = !f && ((s ? q2.size() : q1.size()) < int'(D));
        chk("in_ready", W'(in_ready), W'(exp_ir));
        chk("d1_count", W'(d1_count), W'(q1.size()));
        chk("d2_count", W'(d2_count), W'(q2.size()));
        chk("d1_valid", W'(d1_valid), W'(q1.size() != 0));
        chk("d2_valid", W'(d2_valid), W'(q2.size() != 0));
        if (q1.size() == 0) chk("d1_data idle", d1_data, '0);
        if (q2.size() == 0) chk("d2_data idle", d2_data, '0);
        if (f) begin
            q1.delete();
            q2.delete();
        end else begin
            if (q1.size() != 0 && r1) chk("d1_data", d1_data, q1.pop_front());
            else if (q1.size() != 0)  chk("d1_head", d1_data, q1[0]);
            if (q2.size() != 0 && r2) chk("d2_data", d2_data, q2.pop_front());
            else if (q2.size() != 0)  chk("d2_head", d2_data, q2[0]);
            if (v && exp_ir) begin
                if (s) q2.push_back(d);
                else   q1.push_back(d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        d1_ready = 1'b0; d2_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_zero("reset");
        rst = 1'b0;

        // steering and per-destination order
        step(1, 0, 32'hA1, 1, 1, 0);
        step(1, 1, 32'hB1, 1, 1, 0);
        step(1, 0, 32'hA2, 1, 1, 0);
        step(0, 0, '0, 1, 1, 0);
        step(0, 0, '0, 1, 1, 0);

        // d1 stalled and full; d2 still flows
        step(1, 0, 32'h11, 0, 1, 0);
        step(1, 0, 32'h12, 0, 1, 0);
        step(1, 0, 32'h13, 0, 1, 0);
        step(1, 1, 32'h21, 0, 1, 0);
        step(0, 0, '0, 0, 1, 0);

        // full d1 popped while a push is presented: push refused, then accepted
        step(1, 0, 32'h13, 1, 1, 0);
        step(1, 0, 32'h13, 0, 1, 0);
        step(0, 0, '0, 1, 1, 0);
        step(0, 0, '0, 1, 1, 0);
        step(0, 0, '0, 1, 1, 0);

        // six back-to-back beats across pointer wrap
        for (int i = 0; i < 6; i++) step(1, 0, W'(32'h30 + i), 1, 1, 0);
        step(0, 0, '0, 1, 1, 0);
        step(0, 0, '0, 1, 1, 0);

        // flush with 2+1 beats queued and a beat offered
        step(1, 0, 32'h41, 0, 0, 0);
        step(1, 0, 32'h42, 0, 0, 0);
        step(1, 1, 32'h43, 0, 0, 0);
        step(1, 1, 32'h55, 1, 1, 1);
        step(0, 0, '0, 0, 0, 0);

        // asynchronous reset between edges with both queues occupied
        step(1, 0, 32'h61, 0, 0, 0);
        step(1, 1, 32'h62, 0, 0, 0);
        in_valid = 1'b0; #2;
        rst = 1'b1; #1;
        check_zero("async rst");
        q1.delete(); q2.delete();
        @(posedge clk); #1;
        rst = 1'b0;

        // traffic resumes
        step(1, 0, 32'h71, 1, 1, 0);
        step(1, 1, 32'h72, 1, 1, 0);
        step(0, 0, '0, 1, 1, 0);

        // random mix
        for (int i = 0; i < 200; i++)
            step(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 19) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
